// File: rtl/servant_bus_scheduler.sv
// Round-robin Wishbone scheduler for ibus, dbus and the external host, with a per-transaction watchdog.
// Optional build macro SERVANT_ARB_EXT_LOCK_EN adds i_ext_lock to keep the bus with the host across transactions.
module servant_bus_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDT    = 32'hDEAD_BEEF
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic        o_dbus_ack,
  input  logic [31:0] i_ext_adr,
  input  logic [31:0] i_ext_dat,
  input  logic [3:0]  i_ext_sel,
  input  logic        i_ext_we,
  input  logic        i_ext_cyc,
  output logic        o_ext_ack,
  output logic [31:0] o_rdt,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic [2:0]  o_grant,
`ifdef SERVANT_ARB_EXT_LOCK_EN
  input  logic        i_ext_lock,
`endif
  output logic        o_timeout
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [2:0]  grant, grant_nxt;
  logic [1:0]  last, last_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  req;
  logic        busy;
  logic        gnt_cyc;
  logic        tmo_hit;
  logic        lock_grant;

  // Winner is the first requester after the last-granted master, ibus -> dbus -> ext.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
    logic [2:0] g;
    g = 3'b000;
    case (l)
      2'd0:    if (r[1]) g = 3'b010; else if (r[2]) g = 3'b100; else if (r[0]) g = 3'b001;
      2'd1:    if (r[2]) g = 3'b100; else if (r[0]) g = 3'b001; else if (r[1]) g = 3'b010;
      default: if (r[0]) g = 3'b001; else if (r[1]) g = 3'b010; else if (r[2]) g = 3'b100;
    endcase
    return g;
  endfunction

  function automatic logic [1:0] grant_idx(input logic [2:0] g);
    return g[0] ? 2'd0 : (g[1] ? 2'd1 : 2'd2);
  endfunction

  assign req     = {i_ext_cyc, i_dbus_cyc, i_ibus_cyc};
  assign busy    = (state == BUSY);
  assign gnt_cyc = |(grant & req);
  // A real ack in the last watchdog cycle wins over the forced termination.
  assign tmo_hit = busy & ~i_wb_ack & gnt_cyc & (cnt == TMO_LAST);
  assign o_grant = grant;

`ifdef SERVANT_ARB_EXT_LOCK_EN
  logic ext_held;

  always_ff @(posedge i_clk) begin
    if (!i_nrst)
      ext_held <= 1'b0;
    else if (busy && i_wb_ack)
      ext_held <= grant[2];
  end

  assign lock_grant = ext_held & i_ext_lock & i_ext_cyc;
`else
  assign lock_grant = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state <= IDLE;
      grant <= 3'b000;
      last  <= 2'd2;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        grant_nxt = 3'b000;
        cnt_nxt   = 16'd0;
        if (lock_grant) begin
          state_nxt = BUSY;
          grant_nxt = 3'b100;
        end else if (|req) begin
          state_nxt = BUSY;
          grant_nxt = rr_pick(req, last);
        end
      end
      default: begin
        if (i_wb_ack) begin
          state_nxt = IDLE;
          grant_nxt = 3'b000;
          last_nxt  = grant_idx(grant);
        end else if (!gnt_cyc || tmo_hit) begin
          state_nxt = IDLE;
          grant_nxt = 3'b000;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
    endcase
  end

  always_comb begin
    o_wb_adr = 32'd0;
    o_wb_dat = 32'd0;
    o_wb_sel = 4'd0;
    o_wb_we  = 1'b0;
    if (grant[0]) begin
      o_wb_adr = i_ibus_adr;
      o_wb_sel = 4'hF;
    end else if (grant[1]) begin
      o_wb_adr = i_dbus_adr;
      o_wb_dat = i_dbus_dat;
      o_wb_sel = i_dbus_sel;
      o_wb_we  = i_dbus_we;
    end else if (grant[2]) begin
      o_wb_adr = i_ext_adr;
      o_wb_dat = i_ext_dat;
      o_wb_sel = i_ext_sel;
      o_wb_we  = i_ext_we;
    end
    o_wb_cyc   = busy & gnt_cyc;
    o_ibus_ack = busy & grant[0] & (i_wb_ack | tmo_hit);
    o_dbus_ack = busy & grant[1] & (i_wb_ack | tmo_hit);
    o_ext_ack  = busy & grant[2] & (i_wb_ack | tmo_hit);
    o_timeout  = tmo_hit;
    o_rdt      = tmo_hit ? TIMEOUT_RDT : i_wb_rdt;
  end

endmodule

// File: tb/tb_servant_bus_scheduler.sv
// Directed bench for servant_bus_scheduler, built with an 8-cycle watchdog.
module tb_servant_bus_scheduler;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] ibus_adr, dbus_adr, dbus_dat, ext_adr, ext_dat, wb_rdt;
  logic        ibus_cyc, dbus_cyc, dbus_we, ext_cyc, ext_we, wb_ack;
  logic [3:0]  dbus_sel, ext_sel;
  logic        ibus_ack, dbus_ack, ext_ack, wb_we, wb_cyc, tmo;
  logic [31:0] rdt, wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic [2:0]  grant;
`ifdef SERVANT_ARB_EXT_LOCK_EN
  logic        ext_lock;
`endif

  int vec  = 0;
  int miss = 0;

  always #5 clk = ~clk;

  servant_bus_scheduler #(.TIMEOUT_CYCLES(8), .TIMEOUT_RDT(32'hDEAD_BEEF)) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_ack(ibus_ack),
    .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel),
    .i_dbus_we(dbus_we), .i_dbus_cyc(dbus_cyc), .o_dbus_ack(dbus_ack),
    .i_ext_adr(ext_adr), .i_ext_dat(ext_dat), .i_ext_sel(ext_sel),
    .i_ext_we(ext_we), .i_ext_cyc(ext_cyc), .o_ext_ack(ext_ack),
    .o_rdt(rdt), .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel),
    .o_wb_we(wb_we), .o_wb_cyc(wb_cyc), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack),
    .o_grant(grant),
`ifdef SERVANT_ARB_EXT_LOCK_EN
    .i_ext_lock(ext_lock),
`endif
    .o_timeout(tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    logic [2:0]  rr_g [8];
    logic [31:0] rr_a [8];
    nrst = 1'b0;
    ibus_adr = '0; ibus_cyc = 1'b0;
    dbus_adr = '0; dbus_dat = '0; dbus_sel = '0; dbus_we = 1'b0; dbus_cyc = 1'b0;
    ext_adr = '0; ext_dat = '0; ext_sel = '0; ext_we = 1'b0; ext_cyc = 1'b0;
    wb_rdt = '0; wb_ack = 1'b0;
`ifdef SERVANT_ARB_EXT_LOCK_EN
    ext_lock = 1'b0;
`endif
    tick(); tick(); tick();
    #1;
    chk("rst_grant", grant, 3'b000);
    chk("rst_cyc", wb_cyc, 1'b0);
    chk("rst_sel", wb_sel, 4'h0);
    chk("rst_timeout", tmo, 1'b0);
    chk("rst_acks", {ext_ack, dbus_ack, ibus_ack}, 3'b000);

    // single ibus fetch, zero-wait slave
    tick();
    nrst = 1'b1; ibus_cyc = 1'b1; ibus_adr = 32'hC000_0000;
    #1;
    chk("ib_latency_cyc", wb_cyc, 1'b0);
    tick();
    wb_ack = 1'b1; wb_rdt = 32'h1234_5678;
    #1;
    chk("ib_grant", grant, 3'b001);
    chk("ib_cyc", wb_cyc, 1'b1);
    chk("ib_adr", wb_adr, 32'hC000_0000);
    chk("ib_sel", wb_sel, 4'hF);
    chk("ib_we", wb_we, 1'b0);
    chk("ib_acks", {ext_ack, dbus_ack, ibus_ack}, 3'b001);
    chk("ib_rdt", rdt, 32'h1234_5678);
    tick();
    wb_ack = 1'b0; ibus_cyc = 1'b0;
    #1;
    chk("ib_idle_grant", grant, 3'b000);
    chk("ib_idle_ack", ibus_ack, 1'b0);
    chk("ib_idle_cyc", wb_cyc, 1'b0);

    // stray ack while idle
    tick();
    wb_ack = 1'b1;
    #1;
    chk("stray_acks", {ext_ack, dbus_ack, ibus_ack}, 3'b000);
    tick();
    wb_ack = 1'b0;
    #1;
    chk("stray_grant", grant, 3'b000);

    // reset so the pointer is back at ext, then all three request continuously
    tick();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    ibus_cyc = 1'b1; dbus_cyc = 1'b1; ext_cyc = 1'b1;
    ibus_adr = 32'h100; dbus_adr = 32'h200; ext_adr = 32'h300; wb_ack = 1'b1;
    rr_g = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
    rr_a = '{32'h100, 32'h0, 32'h200, 32'h0, 32'h300, 32'h0, 32'h100, 32'h0};
    for (int i = 0; i < 8; i++) begin
      tick();
      #1;
      chk($sformatf("rr_grant%0d", i), grant, rr_g[i]);
      chk($sformatf("rr_adr%0d", i), wb_adr, rr_a[i]);
      chk($sformatf("rr_acks%0d", i), {ext_ack, dbus_ack, ibus_ack}, rr_g[i]);
    end
    ibus_cyc = 1'b0; dbus_cyc = 1'b0; ext_cyc = 1'b0; wb_ack = 1'b0;

    // dbus write, slave acks immediately
    tick();
    dbus_cyc = 1'b1; dbus_adr = 32'h4000_0000; dbus_dat = 32'h1; dbus_sel = 4'hF; dbus_we = 1'b1;
    #1;
    chk("dw_latency_cyc", wb_cyc, 1'b0);
    tick();
    wb_ack = 1'b1;
    #1;
    chk("dw_grant", grant, 3'b010);
    chk("dw_we", wb_we, 1'b1);
    chk("dw_dat", wb_dat, 32'h1);
    chk("dw_adr", wb_adr, 32'h4000_0000);
    chk("dw_acks", {ext_ack, dbus_ack, ibus_ack}, 3'b010);
    tick();
    dbus_cyc = 1'b0; dbus_we = 1'b0; wb_ack = 1'b0;
    #1;
    chk("dw_idle_we", wb_we, 1'b0);
    chk("dw_idle_grant", grant, 3'b000);

    // ext read against a dead slave: watchdog fires in the 8th busy cycle
    tick();
    ext_cyc = 1'b1; ext_adr = 32'h500; ext_we = 1'b0; wb_rdt = 32'h1111_1111;
    tick();
    #1;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin
        tick();
        #1;
      end
      chk($sformatf("to_grant%0d", k), grant, 3'b100);
      chk($sformatf("to_flag%0d", k), tmo, (k == 8));
      chk($sformatf("to_ack%0d", k), ext_ack, (k == 8));
      chk($sformatf("to_rdt%0d", k), rdt, (k == 8) ? 32'hDEAD_BEEF : 32'h1111_1111);
    end
    ext_cyc = 1'b0;
    tick();
    #1;
    chk("to_idle_grant", grant, 3'b000);
    chk("to_idle_flag", tmo, 1'b0);

    // dbus aborts in its 2nd busy cycle; pending ibus gets the bus next
    tick();
    dbus_cyc = 1'b1; dbus_adr = 32'h600;
    tick();
    ibus_cyc = 1'b1; ibus_adr = 32'hC000_0004;
    #1;
    chk("ab_grant", grant, 3'b010);
    chk("ab_cyc1", wb_cyc, 1'b1);
    tick();
    dbus_cyc = 1'b0;
    #1;
    chk("ab_cyc_gated", wb_cyc, 1'b0);
    chk("ab_acks", {ext_ack, dbus_ack, ibus_ack}, 3'b000);
    tick();
    #1;
    chk("ab_idle_grant", grant, 3'b000);
    tick();
    wb_ack = 1'b1;
    #1;
    chk("ab_next_grant", grant, 3'b001);
    chk("ab_next_adr", wb_adr, 32'hC000_0004);
    chk("ab_next_acks", {ext_ack, dbus_ack, ibus_ack}, 3'b001);
    tick();
    ibus_cyc = 1'b0; wb_ack = 1'b0;

    // real ack in the last watchdog cycle wins
    tick();
    ext_cyc = 1'b1; ext_adr = 32'h700;
    tick();
    for (int k = 1; k < 8; k++) tick();
    wb_ack = 1'b1; wb_rdt = 32'hAAAA_5555;
    #1;
    chk("race_grant", grant, 3'b100);
    chk("race_flag", tmo, 1'b0);
    chk("race_ack", ext_ack, 1'b1);
    chk("race_rdt", rdt, 32'hAAAA_5555);
    tick();
    ext_cyc = 1'b0; wb_ack = 1'b0;

    // reset in the middle of a dbus transfer
    tick();
    dbus_cyc = 1'b1; dbus_adr = 32'h800;
    tick();
    #1;
    chk("mr_grant", grant, 3'b010);
    nrst = 1'b0;
    tick();
    wb_ack = 1'b1;
    #1;
    chk("mr_grant_drop", grant, 3'b000);
    chk("mr_cyc", wb_cyc, 1'b0);
    chk("mr_acks", {ext_ack, dbus_ack, ibus_ack}, 3'b000);
    nrst = 1'b1; dbus_cyc = 1'b0; wb_ack = 1'b0;
    tick();

`ifdef SERVANT_ARB_EXT_LOCK_EN
    // host lock: ext keeps the bus while ibus waits
    begin
      logic [2:0] lk_g [7];
      lk_g = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b001};
      ext_cyc = 1'b1; ext_adr = 32'h900; ext_lock = 1'b1; wb_ack = 1'b1;
      for (int i = 0; i < 7; i++) begin
        tick();
        ibus_cyc = 1'b1;
        #1;
        chk($sformatf("lk_grant%0d", i), grant, lk_g[i]);
        if (i == 4) ext_lock = 1'b0;
      end
      ibus_cyc = 1'b0; ext_cyc = 1'b0; wb_ack = 1'b0;
      tick();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
